dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 112 +++++++++++
 tb/tb_dmem_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data memory with one transaction in flight and a fixed latency from request to response.
// IDLE accepts a request, WAIT counts down, and RESP holds the answer until the requester takes it.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // With LATENCY=1 the commit happens on the acceptance edge, before the latches hold the request
  assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_err = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_idx = w_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Response is captured, and a store committed, on the edge entering RESP
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_we || w_err) ? 32'd0 : r_mem[w_idx];
        if (w_we && !w_err) begin
          r_mem[w_idx] <= w_wdata;
        end
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign resp_valid = (r_state == S_RESP) && !rst;
  assign resp_rdata = resp_valid ? r_rdata : 32'd0;
  assign resp_err   = resp_valid && r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instances with LATENCY 1, 2 and 3, random traffic, and a
// word-array reference model feeding a scoreboard that a separate monitor drains.
module tb_dmem_responder;

  localparam int unsigned NI    = 3;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [31:0] ref_mem [NI][DEPTH];
  logic        in_resp [NI];
  logic [31:0] h_rdata [NI];
  logic        h_err   [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < int'(NI); g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (g + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  task automatic chk32(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst %0d: got %h, required %h (t=%0t)", name, i, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst %0d: got %b, required %b (t=%0t)", name, i, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(NI); i++)
      for (int j = 0; j < int'(DEPTH); j++) ref_mem[i][j] = 32'd0;
    exp_q.delete();
  endtask

  // Monitor: sampled just after each edge; pops one expectation per new response.
  initial begin
    for (int i = 0; i < int'(NI); i++) in_resp[i] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        for (int i = 0; i < int'(NI); i++) in_resp[i] = 1'b0;
      end else begin
        for (int i = 0; i < int'(NI); i++) begin
          if (in_resp[i] && resp_ready[i]) in_resp[i] = 1'b0;
          chk1("ready_and_valid_exclusive", i, req_ready[i] && resp_valid[i], 1'b0);
          if (resp_valid[i]) begin
            if (!in_resp[i]) begin
              if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp inst %0d: got rdata %h err %b, required no response",
                         i, resp_rdata[i], resp_err[i]);
              end else begin
                mon_e = exp_q.pop_front();
                chk32("rdata", i, resp_rdata[i], mon_e.rdata);
                chk1("err", i, resp_err[i], mon_e.err);
                // LATENCY=i+1: first visible right after edge acc+LATENCY-1, taken at edge acc+LATENCY
                chk32("resp_latency", i, 32'(cyc - mon_e.acc), 32'(i));
              end
              in_resp[i] = 1'b1;
              h_rdata[i] = resp_rdata[i];
              h_err[i]   = resp_err[i];
            end else begin
              chk32("hold_rdata", i, resp_rdata[i], h_rdata[i]);
              chk1("hold_err", i, resp_err[i], h_err[i]);
            end
          end
        end
      end
    end
  end

  // Caller is at a negedge; reset is held for two edges, then released.
  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < int'(NI); i++) begin
        chk1("rst_req_ready", i, req_ready[i], 1'b0);
        chk1("rst_resp_valid", i, resp_valid[i], 1'b0);
        chk32("rst_resp_rdata", i, resp_rdata[i], 32'd0);
        chk1("rst_resp_err", i, resp_err[i], 1'b0);
      end
    end
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    for (int i = 0; i < int'(NI); i++) chk1("req_ready_after_rst", i, req_ready[i], 1'b1);
  endtask

  task automatic issue(input int i, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int stall);
    int          n;
    exp_t        e;
    logic [29:0] idx;
    logic        err;
    @(negedge clk);
    req_valid[i]  = 1'b1;
    req_we[i]     = we;
    req_addr[i]   = addr;
    req_wdata[i]  = wdata;
    resp_ready[i] = (stall == 0);
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst %0d: got req_ready 0 for 50 cycles, required 1", i);
      req_valid[i] = 1'b0;
      return;
    end
    idx    = addr[31:2];
    err    = (addr[1:0] != 2'b00) || (idx >= 30'(DEPTH));
    e.inst = i;
    e.err  = err;
    e.acc  = cyc + 1;
    e.rdata = (we || err) ? 32'd0 : ref_mem[i][idx[7:0]];
    if (we && !err) ref_mem[i][idx[7:0]] = wdata;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid[i] = 1'b0;
    req_we[i]    = 1'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    n = 0;
    while (!resp_valid[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid[i]) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout inst %0d: got resp_valid 0 for 50 cycles, required 1", i);
      return;
    end
    // Stalled response: stray requests must be ignored while busy
    for (int s = 0; s < stall; s++) begin
      chk1("req_ready_busy", i, req_ready[i], 1'b0);
      req_valid[i] = 1'b1;
      req_we[i]    = 1'($urandom);
      req_addr[i]  = $urandom;
      req_wdata[i] = $urandom;
      @(negedge clk);
    end
    req_valid[i]  = 1'b0;
    resp_ready[i] = 1'b1;
    @(negedge clk);
    resp_ready[i] = 1'b0;
    chk1("req_ready_after_hs", i, req_ready[i], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by t=%0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          mode;
    rst = 1'b1;
    for (int i = 0; i < int'(NI); i++) begin
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_addr[i]   = 32'd0;
      req_wdata[i]  = 32'd0;
      resp_ready[i] = 1'b0;
    end
    clear_model();
    @(negedge clk);
    do_reset();

    // LATENCY=2: directed store/load, misaligned, out of range, backpressure
    issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    issue(1, 1'b0, 32'h10, 32'h0, 0);
    issue(1, 1'b1, 32'h11, 32'h12345678, 0);
    issue(1, 1'b0, 32'h10, 32'h0, 0);
    issue(1, 1'b0, 32'h400, 32'h0, 0);
    issue(1, 1'b1, 32'h400, 32'hCAFEF00D, 1);
    issue(1, 1'b0, 32'h0, 32'h0, 0);
    issue(1, 1'b0, 32'h10, 32'h0, 5);
    for (int k = 0; k < 30; k++) begin
      mode = int'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 15)) << 2;
      if (mode == 0) a = a | 32'($urandom_range(1, 3));
      if (mode == 1) a = 32'(DEPTH + $urandom_range(0, 1000)) << 2;
      issue(1, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
    end

    // LATENCY=1 sweep over a small word window so loads hit earlier stores
    for (int k = 0; k < 100; k++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      issue(0, 1'($urandom), a, $urandom, int'($urandom_range(0, 1)));
    end

    // LATENCY=3: reset one cycle after accepting a store
    @(negedge clk);
    req_valid[2]  = 1'b1;
    req_we[2]     = 1'b1;
    req_addr[2]   = 32'h20;
    req_wdata[2]  = 32'hA5A5A5A5;
    resp_ready[2] = 1'b1;
    chk1("req_ready_pre_accept", 2, req_ready[2], 1'b1);
    @(negedge clk);
    req_valid[2]  = 1'b0;
    resp_ready[2] = 1'b0;
    chk1("req_ready_accepted", 2, req_ready[2], 1'b0);
    do_reset();
    repeat (6) @(negedge clk);
    issue(2, 1'b0, 32'h20, 32'h0, 0);
    issue(1, 1'b0, 32'h10, 32'h0, 0);
    for (int k = 0; k < 10; k++) begin
      a = 32'($urandom_range(6, 10)) << 2;
      issue(2, 1'($urandom), a, $urandom, int'($urandom_range(0, 2)));
    end

    repeat (4) @(negedge clk);
    chk32("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
